// File: rtl/inst_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_bridge
// Purpose  : Adapts the core's single-cycle instruction port to a req/ack bus,
//            with a one-entry holding register and a bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_bridge #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        stallreq_o,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [15:0] c_limit = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_hold_valid;
    logic [29:0] r_hold_addr;
    logic [31:0] r_hold_data;
    logic [29:0] r_req_addr;
    logic [15:0] r_cnt;
    logic        r_err;
    logic        r_bus_req;
    logic [31:0] r_bus_addr;

    logic        w_hit;
    logic        w_miss;
    logic        w_idle;
    logic        w_expire;
    logic        w_unused;

    assign w_hit    = rom_ce_i & r_hold_valid & (rom_addr_i[31:2] == r_hold_addr);
    assign w_miss   = rom_ce_i & ~w_hit;
    assign w_idle   = (r_state == ST_IDLE);
    assign w_expire = (r_cnt == c_limit);
    assign w_unused = &{1'b0, rom_addr_i[1:0]};

    assign stallreq_o = ~w_idle | w_miss;
    assign rom_data_o = (w_idle & w_hit) ? r_hold_data : 32'd0;
    assign bus_req_o  = r_bus_req;
    assign bus_addr_o = r_bus_addr;
    assign err_o      = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hold_valid <= 1'b0;
            r_hold_addr  <= 30'd0;
            r_hold_data  <= 32'd0;
            r_req_addr   <= 30'd0;
            r_cnt        <= 16'd0;
            r_err        <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_addr   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_req_addr <= rom_addr_i[31:2];
                        r_cnt      <= 16'd0;
                        r_bus_req  <= 1'b1;
                        r_bus_addr <= {rom_addr_i[31:2], 2'b00};
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An ack in the same cycle as a flush still fills the holding register.
                    if (bus_ack_i) begin
                        r_hold_valid <= 1'b1;
                        r_hold_addr  <= r_req_addr;
                        r_hold_data  <= bus_rdata_i;
                        r_bus_req    <= 1'b0;
                        r_bus_addr   <= 32'd0;
                        r_state      <= ST_IDLE;
                    end else if (w_expire) begin
                        r_err        <= 1'b1;
                        r_hold_valid <= 1'b1;
                        r_hold_addr  <= r_req_addr;
                        r_hold_data  <= NOP_INST;
                        r_bus_req    <= 1'b0;
                        r_bus_addr   <= 32'd0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        if (flush_i) begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    // The request stays on the bus until acked; its data is thrown away.
                    if (bus_ack_i || w_expire) begin
                        r_err      <= r_err | (~bus_ack_i & w_expire);
                        r_bus_req  <= 1'b0;
                        r_bus_addr <= 32'd0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_bus_req  <= 1'b0;
                    r_bus_addr <= 32'd0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Adapts the CPU's single-cycle instruction port (rom_ce / rom_addr / rom_data) to a variable-latency request/acknowledge instruction bus. It sits directly upstream of the pc_reg → if_id fetch path: it supplies rom_data to the core and raises a stall request to ctrl while a fetch is outstanding. A one-entry fetch holding register returns data for repeated addresses during stalls without re-issuing bus traffic. A timeout counter substitutes a NOP if the bus never acknowledges.

## Interface
Parameters:
- TIMEOUT, 64: BUSY cycles without bus_ack_i before the fetch is abandoned. Legal range is 2..65535.
- NOP_INST, 32'h0000_0013: instruction returned on timeout (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- rom_ce_i  input  1  core fetch enable
- rom_addr_i  input  32  core fetch byte address (pc)
- rom_data_o  output  32  instruction to if_id; valid when stallreq_o=0 and rom_ce_i=1
- stallreq_o  output  1  stall request to ctrl; freezes pc_reg and if_id
- flush_i  input  1  branch/redirect; cancels any outstanding fetch
- bus_req_o  output  1  bus read request
- bus_addr_o  output  32  bus word address, {addr[31:2],2'b00}
- bus_ack_i  input  1  bus read data valid, one-cycle pulse
- bus_rdata_i  input  32  bus read data, sampled when bus_ack_i=1
- err_o  output  1  sticky timeout flag; cleared only by rst

## Operation
- Holding register: hold_valid (1 bit), hold_addr (30 bits, word address), hold_data (32 bits).
- hit = rom_ce_i & hold_valid & (rom_addr_i[31:2] == hold_addr). The low two address bits are ignored.
- States: IDLE, BUSY, DROP.
- IDLE:
  - rom_ce_i=0: rom_data_o=0, stallreq_o=0, no request.
  - hit: rom_data_o=hold_data, stallreq_o=0.
  - miss: stallreq_o=1 combinationally. Latch req_addr=rom_addr_i[31:2], clear the timeout counter, go to BUSY.
  - flush_i in IDLE: no effect on the state; stallreq_o still follows hit/miss.
- BUSY:
  - bus_req_o=1, bus_addr_o={req_addr,2'b00}, stallreq_o=1, counter increments.
  - On bus_ack_i: load hold_data=bus_rdata_i, hold_addr=req_addr, hold_valid=1, then go to IDLE.
  - On flush_i without bus_ack_i: go to DROP. bus_req_o stays high, because a request is never withdrawn before its ack.
  - flush_i and bus_ack_i in the same cycle: ack wins, data is loaded, and the state goes to IDLE. The redirected pc then misses naturally.
  - Counter reaches TIMEOUT-1 without ack: set err_o. Load hold_data=NOP_INST, hold_addr=req_addr, hold_valid=1. Deassert bus_req_o next cycle and go to IDLE. This is the only case where a request is abandoned.
- DROP:
  - bus_req_o=1 with the old address, stallreq_o=1.
  - On bus_ack_i: discard the data, leave the holding register unchanged, go to IDLE.
  - The timeout also applies in DROP: on expiry go to IDLE and set err_o, with no holding-register load.
- rom_data_o=0 whenever stallreq_o=1.
- bus_addr_o=0 when bus_req_o=0.

## Timing
- Reset values (rst=1 at an edge):
  - state=IDLE, hold_valid=0, hold_addr=0, hold_data=0, counter=0, err_o=0.
  - Outputs after reset: bus_req_o=0, bus_addr_o=0, rom_data_o=0. stallreq_o=0 unless rom_ce_i=1, since the first fetch always misses.
- rst asserted mid-BUSY/DROP: the state returns to IDLE, bus_req_o drops next cycle, and any later stray ack is ignored in IDLE.
- Miss latency with ack arriving L cycles after bus_req_o rises (L≥1):
  - cycle 0: miss detected, stall.
  - cycles 1..L: BUSY.
  - cycle L+1: hit, stallreq_o=0, data presented.
  - Total stall is L+1 cycles. Minimum is 2 with an ack in the first BUSY cycle.
- Hit latency: 0 cycles (combinational from the holding register).
- bus_req_o, bus_addr_o and err_o are registered-state-derived with no combinational path from bus_ack_i.
- stallreq_o and rom_data_o depend combinationally on rom_addr_i, rom_ce_i and state.
- A bus_ack_i received in IDLE is ignored.

## Test plan
- Cold fetch: release rst, rom_ce_i=1, addr 0x0000_0000, ack 1 cycle after req with rdata 0x0010_0093 -> stallreq_o high 2 cycles, then rom_data_o=0x0010_0093 with stallreq_o=0; exactly one bus_req_o burst.
- Repeated/low-bit hit: fetch 0x100 (data 0xDEADBEEF), then hold addr 0x100 for 5 cycles and present 0x102 -> no further bus_req_o, rom_data_o=0xDEADBEEF throughout, stallreq_o=0.
- Flush mid-fetch: miss on 0x200 (ack L=4), flush_i at BUSY cycle 2 with addr changed to 0x300 -> bus_req_o held at 0x200 until ack, 0x200 data discarded, then new request to 0x300; hold_addr never equals 0x200.
- Simultaneous flush+ack: flush_i and bus_ack_i same cycle on 0x400 with data 0x1111_1111 -> hold loaded with 0x1111_1111 for 0x400, state IDLE, next address misses.
- Timeout: TIMEOUT=8, never ack on 0x500 -> bus_req_o high exactly 8 cycles, err_o=1 and stays 1, rom_data_o=0x0000_0013 next cycle; a later ack pulse has no effect.
- Reset mid-operation: rst pulsed during BUSY -> all outputs zero next cycle, err_o=0, hold_valid=0, next fetch misses.
